sum_normalize_stage: RTL

- Stage directly downstream of the mantissa-sum/shift stage in the pipelined FPU adder.
- Consumes that stage's `answer` / `denormilize` result plus the raw 25-bit mantissa sum.
- Passes already-normalised results through unchanged.
- Otherwise renormalises by iterative left shift with exponent decrement, producing a normal, subnormal or zero `float_point_num`.
- Ready/valid handshake on both sides, so the FPU pipeline can stall around the variable-latency normalisation.

---
 rtl/float_types_pkg.sv | 10 +
 rtl/sum_normalize_stage_if.sv | 30 +++
 rtl/sum_normalize_stage.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/float_types_pkg.sv
// Shared single-precision float layout used along the FPU adder pipeline.
package float_types_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } float_point_num;

endpackage

// File: rtl/sum_normalize_stage_if.sv
// Handshake and data bundle between the mantissa-sum stage, the normaliser and its consumer.
interface sum_normalize_stage_if #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
);
    logic                               valid_i;
    logic                               ready_o;
    float_types_pkg::float_point_num    answer_i;
    logic                               denorm_i;
    logic [MANT_W+1:0]                  res_mant_i;
    logic                               res_sign_i;
    logic [EXP_W-1:0]                   exp_i;
    logic                               valid_o;
    logic                               ready_i;
    float_types_pkg::float_point_num    answer_o;
    logic                               underflow_o;
    logic                               zero_o;

    // The normalisation stage itself
    modport slave (
        input  valid_i, answer_i, denorm_i, res_mant_i, res_sign_i, exp_i, ready_i,
        output ready_o, valid_o, answer_o, underflow_o, zero_o
    );

    // Surrounding pipeline: upstream producer plus downstream consumer
    modport master (
        output valid_i, answer_i, denorm_i, res_mant_i, res_sign_i, exp_i, ready_i,
        input  ready_o, valid_o, answer_o, underflow_o, zero_o
    );
endinterface

// File: rtl/sum_normalize_stage.sv
// Post-sum normaliser for the FPU adder: iterative left shift with exponent decrement.
// Define SUM_NORMALIZE_LZC_EN to replace the iterative shift with a one-cycle leading-zero count.
module sum_normalize_stage #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    sum_normalize_stage_if.slave bus
);
    import float_types_pkg::*;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state_reg, state_next;
    logic [MANT_W:0]   work_mant_reg, work_mant_next;
    logic [EXP_W-1:0]  work_exp_reg, work_exp_next;
    logic              work_sign_reg, work_sign_next;
    float_point_num    answer_reg, answer_next;
    logic              underflow_reg, underflow_next;
    logic              zero_reg, zero_next;

    // Carry bit of the raw sum is always clear whenever the mantissa is consumed here.
    logic mant_carry_unused;
    assign mant_carry_unused = bus.res_mant_i[MANT_W+1];

`ifdef SUM_NORMALIZE_LZC_EN
    localparam int LZ_W = $clog2(MANT_W + 2);
    logic [LZ_W-1:0] lz_count;
    logic [MANT_W:0] shifted_mant;

    // Ascending scan: the highest set bit is the last one to write the count.
    always_comb begin
        lz_count = LZ_W'(MANT_W + 1);
        for (int i = 0; i <= MANT_W; i++) begin
            if (work_mant_reg[i]) lz_count = LZ_W'(MANT_W - i);
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= IDLE;
            work_mant_reg <= '0;
            work_exp_reg  <= '0;
            work_sign_reg <= 1'b0;
            answer_reg    <= '0;
            underflow_reg <= 1'b0;
            zero_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            work_mant_reg <= work_mant_next;
            work_exp_reg  <= work_exp_next;
            work_sign_reg <= work_sign_next;
            answer_reg    <= answer_next;
            underflow_reg <= underflow_next;
            zero_reg      <= zero_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        work_mant_next = work_mant_reg;
        work_exp_next  = work_exp_reg;
        work_sign_next = work_sign_reg;
        answer_next    = answer_reg;
        underflow_next = underflow_reg;
        zero_next      = zero_reg;
`ifdef SUM_NORMALIZE_LZC_EN
        shifted_mant   = '0;
`endif
        unique case (state_reg)
            IDLE: begin
                if (bus.valid_i) begin
                    underflow_next = 1'b0;
                    zero_next      = 1'b0;
                    if (!bus.denorm_i) begin
                        answer_next = bus.answer_i;
                        state_next  = DONE;
                    end else if (bus.res_mant_i[MANT_W:0] == '0) begin
                        // Exact cancellation always yields +0.
                        answer_next = '0;
                        zero_next   = 1'b1;
                        state_next  = DONE;
                    end else if (bus.exp_i == '0) begin
                        answer_next    = {bus.res_sign_i, {EXP_W{1'b0}}, bus.res_mant_i[MANT_W-1:0]};
                        underflow_next = 1'b1;
                        state_next     = DONE;
                    end else begin
                        work_mant_next = bus.res_mant_i[MANT_W:0];
                        work_exp_next  = bus.exp_i;
                        work_sign_next = bus.res_sign_i;
                        state_next     = SHIFT;
                    end
                end
            end
            SHIFT: begin
`ifdef SUM_NORMALIZE_LZC_EN
                if (EXP_W'(lz_count) < work_exp_reg) begin
                    shifted_mant = work_mant_reg << lz_count;
                    answer_next  = {work_sign_reg, work_exp_reg - EXP_W'(lz_count),
                                    shifted_mant[MANT_W-1:0]};
                end else begin
                    // Not enough exponent headroom: stop at exponent 1 and emit a subnormal.
                    shifted_mant   = work_mant_reg << (work_exp_reg - EXP_W'(1));
                    answer_next    = {work_sign_reg, {EXP_W{1'b0}}, shifted_mant[MANT_W-1:0]};
                    underflow_next = 1'b1;
                end
                state_next = DONE;
`else
                if (work_mant_reg[MANT_W]) begin
                    answer_next = {work_sign_reg, work_exp_reg, work_mant_reg[MANT_W-1:0]};
                    state_next  = DONE;
                end else if (work_exp_reg == EXP_W'(1)) begin
                    // Hidden bit never reached; the value is subnormal at this scale.
                    answer_next    = {work_sign_reg, {EXP_W{1'b0}}, work_mant_reg[MANT_W-1:0]};
                    underflow_next = 1'b1;
                    state_next     = DONE;
                end else begin
                    work_mant_next = work_mant_reg << 1;
                    work_exp_next  = work_exp_reg - EXP_W'(1);
                end
`endif
            end
            DONE: begin
                if (bus.ready_i) begin
                    underflow_next = 1'b0;
                    zero_next      = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.ready_o     = (state_reg == IDLE);
    assign bus.valid_o     = (state_reg == DONE);
    assign bus.answer_o    = answer_reg;
    assign bus.underflow_o = underflow_reg;
    assign bus.zero_o      = zero_reg;

endmodule
